// File: rtl/aes_pkg.sv
// AES shared package: forward round functions and FSM state type.
// Byte i of a 128-bit state sits at bits [8i+7:8i]; byte index = 4*col + row.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } aes_seq_state_t;

  localparam logic [2047:0] SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047-8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  // Row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8] =
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c+8 +: 8] =
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c+16 +: 8] =
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c+24 +: 8] =
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(
    input logic [127:0] s,
    input logic [127:0] k
  );
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One forward AES round, purely combinational.
// The final round (last=1) skips MixColumns.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic         last,
  output logic [127:0] result
);

  logic [127:0] sr;

  assign sr = shift_rows(sub_bytes(state));

  assign result =
    add_round_key(last ? sr : mix_columns(sr), key);

endmodule

// File: rtl/aes_cipher_seq.sv
// Iterative AES encryptor: one round datapath reused Nr times.
// Handshake outputs come straight from registered FSM state.
module aes_cipher_seq
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  rkey [4*(Nr+1)],
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct
);

  localparam int RW = $clog2(Nr + 1);

  aes_seq_state_t state_q;
  logic [RW-1:0]  rnd_q;
  logic [127:0]   st_q;
  logic [127:0]   st_d;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [127:0]   key_sel;
  logic [127:0]   rnd_out;
  logic           last;

  assign last = (rnd_q == RW'(Nr));

  // Round key select; rnd_q is 0 throughout IDLE, giving key0.
  always_comb begin
    key_sel = '0;
    for (int c = 0; c < 4; c++) begin
      key_sel[32*c +: 32] = rkey[4*int'(rnd_q) + c];
    end
  end

  aes_enc_round u_round (
    .state  (st_q),
    .key    (key_sel),
    .last   (last),
    .result (rnd_out)
  );

  // Next datapath state: initial key add on accept, round otherwise.
  always_comb begin
    st_d = st_q;
    unique case (state_q)
      IDLE:    if (in_valid) st_d = add_round_key(pt, key_sel);
      ROUND:   st_d = rnd_out;
      default: st_d = st_q;
    endcase
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      st_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      st_q <= st_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= ROUND;
            rnd_q      <= RW'(1);
            in_ready_q <= 1'b0;
          end
        end
        ROUND: begin
          if (last) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            rnd_q <= rnd_q + RW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            rnd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ct        = st_q;

endmodule
